// File: rtl/operate_uart_tx.sv
// Serialises each new operate code onto an 8N1 UART line, LSB first.
// One-entry pending buffer (newest wins) plus optional keep-alive resend.
module operate_uart_tx #(
  parameter int          CLKS_PER_BIT  = 16,
  parameter logic [7:0]  IDLE_CODE     = 8'h82,
  parameter int          REPEAT_CYCLES = 0
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic [7:0] data_operate,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] overwrite_cnt
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int KW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [KW-1:0] K_LAST =
    KW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit KA_EN = (REPEAT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [2:0]      bit_idx, bit_idx_nx;
  logic [7:0]      shift, shift_nx;
  logic            tx_nx, busy_nx;
  logic [7:0]      last_seen, pend_byte;
  logic            pending;
  logic [KW-1:0]   ka_cnt;
  logic            change, consume, bit_end, ka_fire;

  assign change  = (data_operate != last_seen);
  assign bit_end = (timer == T_LAST);
  assign consume = (state == IDLE) && pending;
  assign ka_fire = KA_EN && (state == IDLE) && !pending
                   && !change && (ka_cnt == K_LAST);
  assign tx_done = (state == STOP) && bit_end;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    tx_nx      = uart_tx;
    busy_nx    = tx_busy;
    unique case (state)
      IDLE: begin
        if (pending) begin
          state_nx   = START;
          timer_nx   = '0;
          bit_idx_nx = '0;
          shift_nx   = pend_byte;
          tx_nx      = 1'b0;
          busy_nx    = 1'b1;
        end
      end
      START: begin
        timer_nx = timer + 1'b1;
        if (bit_end) begin
          state_nx = DATA;
          timer_nx = '0;
          tx_nx    = shift[0];
        end
      end
      DATA: begin
        timer_nx = timer + 1'b1;
        if (bit_end) begin
          timer_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
            shift_nx   = {1'b0, shift[7:1]};
            tx_nx      = shift[1];
          end
        end
      end
      STOP: begin
        timer_nx = timer + 1'b1;
        if (bit_end) begin
          state_nx = IDLE;
          timer_nx = '0;
          busy_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      uart_tx       <= 1'b1;
      tx_busy       <= 1'b0;
      last_seen     <= IDLE_CODE;
      pend_byte     <= IDLE_CODE;
      pending       <= 1'b0;
      overwrite_cnt <= '0;
      ka_cnt        <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      uart_tx <= tx_nx;
      tx_busy <= busy_nx;
      // A change beats both consume and keep-alive; consume+change keeps pending.
      if (change) begin
        last_seen <= data_operate;
        pend_byte <= data_operate;
        pending   <= 1'b1;
        if (pending && !consume && overwrite_cnt != 8'hFF)
          overwrite_cnt <= overwrite_cnt + 1'b1;
      end else if (ka_fire) begin
        pend_byte <= last_seen;
        pending   <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
      if (!KA_EN || change || ka_fire || pending || state != IDLE)
        ka_cnt <= '0;
      else
        ka_cnt <= ka_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_operate_uart_tx.sv
// Scoreboarded bench for operate_uart_tx: line decoder per DUT,
// directed steps for change, overwrite, reset abort and keep-alive.
module tb_operate_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = 8'h82;
  logic [7:0] d_ka = 8'h82;
  logic       tx, busy, done;
  logic       tx_ka, busy_ka, done_ka;
  logic [7:0] ovf, ovf_ka;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nframes = 0;
  int nstarts = 0;
  int aborts = 0;
  int ndone = 0;

  logic [7:0] sb[$];
  int         starts0[$];
  int         ka_starts[$];
  logic [7:0] ka_bytes[$];

  operate_uart_tx #(
    .CLKS_PER_BIT(CPB), .IDLE_CODE(8'h82), .REPEAT_CYCLES(0)
  ) dut (
    .uart_clk(clk), .rst(rst), .data_operate(d),
    .uart_tx(tx), .tx_busy(busy), .tx_done(done),
    .overwrite_cnt(ovf)
  );

  operate_uart_tx #(
    .CLKS_PER_BIT(CPB), .IDLE_CODE(8'h82), .REPEAT_CYCLES(50)
  ) dut_ka (
    .uart_clk(clk), .rst(rst), .data_operate(d_ka),
    .uart_tx(tx_ka), .tx_busy(busy_ka), .tx_done(done_ka),
    .overwrite_cnt(ovf_ka)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) ndone <= ndone + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int w);
    logic [9:0] b;
    logic [7:0] exp;
    int st;
    bit ab, done_ok, busy_ok;
    logic ln;
    @(negedge clk);
    ln = (w != 0) ? tx_ka : tx;
    if (rst || ln !== 1'b0) return;
    st = cyc;
    ab = 0;
    done_ok = 1;
    busy_ok = 1;
    b = '0;
    if (w == 0) nstarts++;
    for (int c = 1; c <= 10 * CPB; c++) begin
      if (c > 1) @(negedge clk);
      if (rst) begin
        ab = 1;
        break;
      end
      ln = (w != 0) ? tx_ka : tx;
      if (c % CPB == CPB / 2) b[c / CPB] = ln;
      if (w == 0) begin
        if (done !== (c == 10 * CPB)) done_ok = 0;
        if (busy !== 1'b1) busy_ok = 0;
      end
    end
    if (ab) begin
      if (w == 0) aborts++;
      return;
    end
    if (w != 0) begin
      ka_starts.push_back(st);
      ka_bytes.push_back(b[8:1]);
      return;
    end
    chk("start_bit", b[0], 1'b0);
    chk("stop_bit", b[9], 1'b1);
    chk("done_pulse", done_ok, 1'b1);
    chk("busy_frame", busy_ok, 1'b1);
    chk("sb_has_entry", sb.size() > 0, 1'b1);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk("frame_byte", b[8:1], exp);
    starts0.push_back(st);
    nframes++;
  endtask

  always mon(0);
  always mon(1);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int lim);
    int tgt, i;
    tgt = nframes + n;
    i = 0;
    while (nframes < tgt && i < lim) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("frame_wait", nframes >= tgt, 1'b1);
  endtask

  initial begin
    int k, s, nd;
    // reset state
    step(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 8'd0);
    rst = 1'b0;
    step(200);
    chk("idle_no_frame", nstarts, 0);
    chk("idle_tx", tx, 1'b1);

    // single change 0x82 -> 0x92
    d = 8'h92;
    sb.push_back(8'h92);
    k = cyc;
    wait_frames(1, 100);
    chk("latency", starts0[starts0.size() - 1], k + 2);
    chk("busy_after", busy, 1'b0);

    // mid-frame change then overwrite
    d = 8'h8A;
    sb.push_back(8'h8A);
    step(8);
    d = 8'hA2;
    step(4);
    d = 8'hC2;
    sb.push_back(8'hC2);
    wait_frames(2, 200);
    s = starts0.size();
    chk("b2b_gap", starts0[s - 1] - starts0[s - 2], 41);
    chk("ovf_one", ovf, 8'd1);

    // change on the consume edge
    d = 8'h86;
    sb.push_back(8'h86);
    step(1);
    d = 8'h92;
    sb.push_back(8'h92);
    wait_frames(2, 200);
    s = starts0.size();
    chk("toggle_gap", starts0[s - 1] - starts0[s - 2], 41);
    chk("toggle_ovf", ovf, 8'd1);

    // reset during data bit 3
    d = 8'h86;
    sb.push_back(8'h86);
    k = cyc;
    step(19);
    nd = ndone;
    rst = 1'b1;
    step(1);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    step(1);
    rst = 1'b0;
    chk("abort_cnt", aborts, 1);
    chk("abort_no_done", ndone, nd);
    chk("abort_ovf", ovf, 8'd0);
    wait_frames(1, 100);

    // keep-alive on the second instance
    d = 8'h82;
    rst = 1'b1;
    step(2);
    ka_starts.delete();
    ka_bytes.delete();
    rst = 1'b0;
    d_ka = 8'hA2;
    k = cyc;
    for (int i = 0; i < 400 && ka_bytes.size() < 3; i++) @(posedge clk);
    #1;
    chk("ka_frames", ka_bytes.size() >= 3, 1'b1);
    if (ka_bytes.size() >= 3) begin
      chk("ka_first", ka_starts[0], k + 2);
      chk("ka_period1", ka_starts[1] - ka_starts[0], 91);
      chk("ka_period2", ka_starts[2] - ka_starts[1], 91);
      for (int i = 0; i < 3; i++) chk("ka_byte", ka_bytes[i], 8'hA2);
    end
    chk("main_quiet", sb.size(), 0);
    chk("ovf_ka", ovf_ka, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
